// File: rtl/lm70_spi_scheduler_pkg.sv
// Shared types and defaults for the LM70 SPI transaction scheduler.
package lm70_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;

  localparam int LM70_CS_GAP         = 2;
  localparam int LM70_CLK_DIV_DEF    = 1;
  localparam int LM70_FRAME_BITS_DEF = 16;
  localparam int LM70_CS_SETUP_DEF   = 2;
endpackage

// File: rtl/lm70_spi_scheduler_if.sv
// Request/grant and response handshake between the scheduler and its two clients.
interface lm70_spi_scheduler_if #(parameter int FRAME_BITS = 16);
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [FRAME_BITS-1:0] rsp_data;

  modport master (output req, rsp_ready, input gnt, rsp_valid, rsp_id, rsp_data);
  modport slave  (input req, rsp_ready, output gnt, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/lm70_spi_scheduler_rr_arb.sv
// 2-way round-robin arbiter: ptr names the requester that wins a tie.
module lm70_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[ptr])       grant[ptr]  = 1'b1;
      else if (req[~ptr]) grant[~ptr] = 1'b1;
    end
  end
endmodule

// File: rtl/lm70_spi_scheduler.sv
// LM70 SPI scheduler: arbitrates two requesters, runs one CS/SCK read each, returns the frame.
// Optional over-temperature flag enabled with `define LM70_ALERT_EN.
module lm70_spi_scheduler
  import lm70_pkg::*;
#(
  parameter int CLK_DIV    = LM70_CLK_DIV_DEF,
  parameter int FRAME_BITS = LM70_FRAME_BITS_DEF,
  parameter int CS_SETUP   = LM70_CS_SETUP_DEF
) (
  input  logic clk,
  input  logic rst,
  lm70_spi_scheduler_if.slave bus,
  output logic cs_n,
  output logic sck,
  input  logic miso
`ifdef LM70_ALERT_EN
  ,
  input  logic [7:0] alert_thresh,
  input  logic       alert_clr,
  output logic       alert
`endif
);
  state_t                state;
  logic                  ptr;
  logic [3:0]            cnt;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [1:0]            win;

  lm70_rr_arb u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cs_n          <= 1'b1;
      sck           <= 1'b0;
      bus.gnt       <= 2'b00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      ptr           <= 1'b0;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
    end else begin
      bus.gnt <= 2'b00;
      case (state)
        IDLE: if (win != 2'b00) begin
          bus.gnt    <= win;
          bus.rsp_id <= win[1];
          cs_n       <= 1'b0;
          cnt        <= '0;
          shreg      <= '0;
          state      <= SETUP;
        end
        SETUP: if (cnt == 4'(CS_SETUP - 1)) begin
          cnt     <= '0;
          bit_cnt <= '0;
          sck     <= 1'b1;
          state   <= SHIFT;
        end else cnt <= cnt + 4'd1;
        SHIFT: if (cnt == 4'(CLK_DIV - 1)) begin
          cnt <= '0;
          if (sck) begin
            // Sample at the end of the high phase; sensor updates after SCK falls.
            sck   <= 1'b0;
            shreg <= {shreg[FRAME_BITS-2:0], miso};
          end else if (bit_cnt == 5'(FRAME_BITS - 1)) begin
            cs_n  <= 1'b1;
            state <= HOLD;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            sck     <= 1'b1;
          end
        end else cnt <= cnt + 4'd1;
        HOLD: if (cnt == 4'(LM70_CS_GAP - 1)) begin
          cnt           <= '0;
          bus.rsp_data  <= shreg;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end else cnt <= cnt + 4'd1;
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          ptr           <= ~bus.rsp_id;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LM70_ALERT_EN
  logic valid_q;

  // Evaluate once per response, on the first cycle it is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      alert   <= 1'b0;
    end else begin
      valid_q <= bus.rsp_valid;
      if (bus.rsp_valid && !valid_q && (bus.rsp_data[FRAME_BITS-1 -: 8] >= alert_thresh))
        alert <= 1'b1;
      else if (alert_clr)
        alert <= 1'b0;
    end
  end
`endif
endmodule
